// File: rtl/guest_ce_reset_gen.sv
// Fractional clock enables from clk_sys plus a stretched, ce-aligned core reset.
// Optional macro GUEST_CE_PHASE_ALIGN_EN: zero every phase accumulator when the core leaves reset.

module guest_ce_reset_gen #(
    parameter int NUM_CE   = 3,
    parameter int ACC_W    = 16,
    parameter int REQ_W    = 3,
    parameter int RST_HOLD = 16
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic [REQ_W-1:0]        rst_req,
    input  logic [NUM_CE*ACC_W-1:0] ce_inc,
    input  logic [NUM_CE-1:0]       ce_en,
    output logic [NUM_CE-1:0]       ce_out,
    output logic                    core_reset,
    output logic                    rst_done
);

    localparam int CNT_W = (RST_HOLD < 1) ? 1 : $clog2(RST_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(RST_HOLD);

    typedef enum logic [1:0] {
        S_ASSERT = 2'd0,
        S_HOLD   = 2'd1,
        S_ALIGN  = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] acc,
                                               input logic [ACC_W-1:0] inc);
        return {1'b0, acc} + {1'b0, inc};
    endfunction

    logic [REQ_W-1:0]             req_sync_p0;
    logic [REQ_W-1:0]             req_sync_p1;
    logic                         req_s;
    logic [NUM_CE-1:0][ACC_W-1:0] acc_q;
    logic [CNT_W-1:0]             hold_cnt;
    state_t                       state_q;
    state_t                       state_d;
    logic                         release_now;

    // Stage p0/p1: independent two-flop synchroniser per request bit
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            req_sync_p0 <= '0;
            req_sync_p1 <= '0;
        end else begin
            req_sync_p0 <= rst_req;
            req_sync_p1 <= req_sync_p0;
        end
    end

    assign req_s = |req_sync_p1;

    // Phase accumulators: the carry of each add becomes next cycle's enable pulse
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            ce_out <= '0;
        end else begin
            for (int i = 0; i < NUM_CE; i++) begin
                if (ce_en[i]) begin
                    {ce_out[i], acc_q[i]} <= acc_add(acc_q[i], ce_inc[i*ACC_W +: ACC_W]);
                end else begin
                    ce_out[i] <= 1'b0;
                end
`ifdef GUEST_CE_PHASE_ALIGN_EN
                if (release_now) begin
                    acc_q[i] <= '0;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= S_ASSERT;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter only lives in HOLD; it saturates at RST_HOLD so it can never wrap
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (state_q != S_HOLD || req_s) begin
            hold_cnt <= '0;
        end else if (ce_out[0] && hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        if (req_s) begin
            state_d = S_ASSERT;
        end else begin
            case (state_q)
                S_ASSERT: state_d = S_HOLD;
                S_HOLD:   if (hold_cnt == HOLD_MAX) state_d = S_ALIGN;
                S_ALIGN:  if (ce_out[0]) state_d = S_RUN;
                S_RUN:    state_d = S_RUN;
                default:  state_d = S_ASSERT;
            endcase
        end
    end

    assign release_now = (state_q == S_ALIGN) && (state_d == S_RUN);

    always_comb begin
        core_reset = (state_q != S_RUN);
    end

    // Single-cycle marker coincident with the first cycle of RUN
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= release_now;
        end
    end

endmodule

// File: tb/tb_guest_ce_reset_gen.sv
// Self-checking bench for guest_ce_reset_gen: vector table, hand sequences and a randomized run
// compared cycle by cycle against a behavioural reference model.

module tb_guest_ce_reset_gen;

    localparam int NUM_CE   = 3;
    localparam int ACC_W    = 16;
    localparam int REQ_W    = 3;
    localparam int RST_HOLD = 16;
    localparam int MOD      = 1 << ACC_W;

    logic                    clk_sys = 1'b0;
    logic                    reset   = 1'b1;
    logic [REQ_W-1:0]        rst_req = '0;
    logic [NUM_CE*ACC_W-1:0] ce_inc  = '0;
    logic [NUM_CE-1:0]       ce_en   = '0;
    logic [NUM_CE-1:0]       ce_out;
    logic                    core_reset;
    logic                    rst_done;

    guest_ce_reset_gen #(
        .NUM_CE(NUM_CE), .ACC_W(ACC_W), .REQ_W(REQ_W), .RST_HOLD(RST_HOLD)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .rst_req(rst_req), .ce_inc(ce_inc),
        .ce_en(ce_en), .ce_out(ce_out), .core_reset(core_reset), .rst_done(rst_done)
    );

    always #5 clk_sys = ~clk_sys;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: integer phases, a two-deep request history, and the reset
    // sequence as "requested / pulses still owed / waiting for an enable edge".
    int m_acc [NUM_CE];
    bit m_ce  [NUM_CE];
    bit m_hist1, m_hist2;
    bit m_req_active, m_armed, m_core_reset, m_done;
    int m_left;

    function automatic void model_reset();
        for (int i = 0; i < NUM_CE; i++) begin
            m_acc[i] = 0;
            m_ce[i]  = 0;
        end
        m_hist1 = 0; m_hist2 = 0;
        m_req_active = 1; m_armed = 0; m_core_reset = 1; m_done = 0;
        m_left = RST_HOLD;
    endfunction

    function automatic void model_step();
        bit rq, ce0, rel;
        int s;
        rq  = m_hist2;
        ce0 = m_ce[0];
        rel = 0;
        m_hist2 = m_hist1;
        m_hist1 = |rst_req;
        m_done  = 0;
        if (rq) begin
            m_req_active = 1; m_armed = 0; m_core_reset = 1; m_left = RST_HOLD;
        end else if (m_req_active) begin
            m_req_active = 0; m_left = RST_HOLD;
        end else if (m_armed) begin
            if (ce0) begin
                m_armed = 0; m_core_reset = 0; m_done = 1; rel = 1;
            end
        end else if (m_core_reset) begin
            if (m_left == 0) m_armed = 1;
            else if (ce0) m_left--;
        end
        for (int i = 0; i < NUM_CE; i++) begin
            if (ce_en[i]) begin
                s = m_acc[i] + int'(ce_inc[i*ACC_W +: ACC_W]);
                m_ce[i]  = (s >= MOD);
                m_acc[i] = s % MOD;
            end else begin
                m_ce[i] = 0;
            end
        end
`ifdef GUEST_CE_PHASE_ALIGN_EN
        if (rel) for (int i = 0; i < NUM_CE; i++) m_acc[i] = 0;
`endif
    endfunction

    function automatic logic [NUM_CE-1:0] model_ce();
        logic [NUM_CE-1:0] v;
        for (int i = 0; i < NUM_CE; i++) v[i] = m_ce[i];
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        if (reset) model_reset();
        else model_step();
        #1;
        check("cycle {ce_out,core_reset,rst_done}", int'({ce_out, core_reset, rst_done}),
              int'({model_ce(), m_core_reset, m_done}));
    endtask

    task automatic set_inc(input int ch, input int val);
        ce_inc[ch*ACC_W +: ACC_W] = ACC_W'(val);
    endtask

    task automatic req_burst(input logic [REQ_W-1:0] bits, input int len);
        rst_req = bits;
        repeat (len) step();
        rst_req = '0;
        repeat (2) step();
        check("burst_core_reset", int'(core_reset), 1);
    endtask

    // Steps until core_reset falls, counting ce_out[0] pulses seen on the way.
    task automatic measure(output int n, output int last);
        n = 0; last = 0;
        for (int k = 0; k < 2000; k++) begin
            step();
            if (!core_reset) return;
            if (ce_out[0]) n++;
            last = int'(ce_out[0]);
        end
        n = -1;
    endtask

    task automatic wait_pulses(input int want);
        int seen;
        seen = 0;
        for (int k = 0; k < 1000 && seen < want; k++) begin
            step();
            if (ce_out[0]) seen++;
        end
        check("wait_pulses", seen, want);
    endtask

    typedef struct {
        int                inc   [NUM_CE];
        logic [NUM_CE-1:0] en;
        int                cycles;
        int                exp_n [NUM_CE];
        int                sp_ch;
        int                sp_lo;
        int                sp_hi;
    } vec_t;

    vec_t tbl [4];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt [NUM_CE];
        int last_p, sp_bad, n, last, k_rel, k_first0, k_rise0, k_rise1, n_done;
        int ch, v, req_len;

        tbl[0] = '{'{16384, 0, 4260},      3'b111, 65536, '{16384, 0, 4260}, 2, 15, 16};
        tbl[1] = '{'{65535, 1, 32768},     3'b111, 100,   '{99, 0, 50},      -1, 0, 0};
        tbl[2] = '{'{8192, 12345, 40000},  3'b111, 1000,  '{125, 188, 610},  0, 8, 8};
        tbl[3] = '{'{16384, 16384, 16384}, 3'b101, 40,    '{10, 0, 10},      0, 4, 4};

        model_reset();
        #1;
        check("reset_state", int'({ce_out, core_reset, rst_done}), 5'b00010);
        repeat (2) step();

        // Rate table: counts start from a freshly reset accumulator; a request is held so
        // the core never releases (keeps phase-align builds identical).
        for (int r = 0; r < 4; r++) begin
            reset = 1'b1;
            step();
            for (int i = 0; i < NUM_CE; i++) begin
                set_inc(i, tbl[r].inc[i]);
                cnt[i] = 0;
            end
            ce_en   = tbl[r].en;
            rst_req = 3'b100;
            reset   = 1'b0;
            last_p  = -1;
            sp_bad  = 0;
            for (int c = 1; c <= tbl[r].cycles; c++) begin
                step();
                for (int i = 0; i < NUM_CE; i++) begin
                    if (ce_out[i]) begin
                        cnt[i]++;
                        if (i == tbl[r].sp_ch) begin
                            if (last_p >= 0 && (c - last_p < tbl[r].sp_lo || c - last_p > tbl[r].sp_hi))
                                sp_bad++;
                            last_p = c;
                        end
                    end
                end
            end
            for (int i = 0; i < NUM_CE; i++) check($sformatf("tbl%0d_pulses_ch%0d", r, i), cnt[i], tbl[r].exp_n[i]);
            if (tbl[r].sp_ch >= 0) check($sformatf("tbl%0d_spacing", r), sp_bad, 0);
        end

        // Boot: first add at edge 1, ch0 pulse after edge 4; 16 pulses seen by edge 65,
        // ALIGN at 66, next pulse after edge 68 releases the core at edge 69.
        reset = 1'b1;
        step();
        set_inc(0, 16384); set_inc(1, 8192); set_inc(2, 4260);
        ce_en = 3'b111; rst_req = '0; reset = 1'b0;
        k_first0 = -1; k_rel = -1; k_rise0 = -1; k_rise1 = -1; n_done = 0;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (ce_out[0] && k_first0 < 0) k_first0 = k;
            if (!core_reset && k_rel < 0) k_rel = k;
            if (rst_done) n_done++;
            if (k_rel > 0 && k > k_rel && ce_out[0] && k_rise0 < 0) k_rise0 = k;
            if (k_rel > 0 && k > k_rel && ce_out[1] && k_rise1 < 0) k_rise1 = k;
        end
        check("boot_first_ce0", k_first0, 4);
        check("boot_release_cycle", k_rel, 69);
        check("boot_rst_done_count", n_done, 1);
`ifdef GUEST_CE_PHASE_ALIGN_EN
        check("align_ce0_after_run", k_rise0 - k_rel, 4);
        check("align_ce1_after_run", k_rise1 - k_rel, 8);
`endif

        // rst_req[1] for 10 cycles: core_reset rises two cycles after the first sampling edge
        rst_req = 3'b010;
        step(); check("req_latency_e1", int'(core_reset), 0);
        step(); check("req_latency_e2", int'(core_reset), 0);
        step(); check("req_latency_e3", int'(core_reset), 1);
        repeat (7) step();
        rst_req = '0;
        repeat (2) step();
        measure(n, last);
        check("hold_pulses", n, RST_HOLD + 1);
        check("hold_last_is_ce0", last, 1);
        check("rst_done_on_release", int'(rst_done), 1);
        step();
        check("rst_done_one_cycle", int'(rst_done), 0);

        // Re-request at hold count 9 restarts the full hold
        req_burst(3'b001, 1);
        wait_pulses(9);
        req_burst(3'b001, 1);
        measure(n, last);
        check("restart_hold_pulses", n, RST_HOLD + 1);

        // ce_en[0] low mid-hold freezes the count; only the remaining pulses follow
        req_burst(3'b100, 3);
        wait_pulses(5);
        ce_en[0] = 1'b0;
        sp_bad = 0;
        repeat (100) begin
            step();
            if (ce_out[0]) sp_bad++;
        end
        check("stall_ce0_quiet", sp_bad, 0);
        check("stall_core_reset", int'(core_reset), 1);
        ce_en[0] = 1'b1;
        measure(n, last);
        check("stall_remaining_pulses", n, RST_HOLD + 1 - 5);

        // Async reset between edges while running
        for (int k = 0; k < 20 && ce_out == '0; k++) step();
        check("pre_async_ce_active", int'(ce_out != '0), 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", int'({ce_out, core_reset, rst_done}), 5'b00010);
        model_reset();
        step();
        reset = 1'b0;

        // Randomized run against the model
        req_len = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                ch = int'($urandom_range(0, NUM_CE - 1));
                case ($urandom_range(0, 3))
                    0:       v = 0;
                    1:       v = 16384;
                    2:       v = 65535;
                    default: v = int'($urandom_range(0, 65535));
                endcase
                set_inc(ch, v);
            end
            if ($urandom_range(0, 63) == 0) begin
                ch = int'($urandom_range(0, NUM_CE - 1));
                ce_en[ch] = ~ce_en[ch];
            end
            if (req_len == 0 && $urandom_range(0, 299) == 0) begin
                req_len = int'($urandom_range(1, 12));
                rst_req = REQ_W'($urandom_range(1, 7));
            end
            step();
            if (req_len > 0) begin
                req_len--;
                if (req_len == 0) rst_req = '0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
